// File: rtl/vga_mem_arbiter.sv
// Two-master Wishbone arbiter sharing the video memory port between display fetch and CPU/DMA.
// Video has priority; a saturating wait counter lets a starved CPU win the next arbitration.
module vga_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned CPU_WAIT_MAX    = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // video fetch requester
   input  logic        vid_cyc,
   input  logic        vid_stb,
   input  logic [31:0] vid_adr,
   input  logic        vid_we,
   input  logic [3:0]  vid_sel,
   input  logic [31:0] vid_dat_m,
   output logic [31:0] vid_dat_s,
   output logic        vid_ack,
   output logic        vid_stall,
   // CPU/DMA requester
   input  logic        cpu_cyc,
   input  logic        cpu_stb,
   input  logic [31:0] cpu_adr,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_sel,
   input  logic [31:0] cpu_dat_m,
   output logic [31:0] cpu_dat_s,
   output logic        cpu_ack,
   output logic        cpu_stall,
   // shared memory port
   output logic        mem_cyc,
   output logic        mem_stb,
   output logic [31:0] mem_adr,
   output logic        mem_we,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_dat_m,
   input  logic [31:0] mem_dat_s,
   input  logic        mem_ack,
   input  logic        mem_stall,
   output logic [1:0]  gnt,
   output logic        cpu_starve
);

   localparam int unsigned OUT_W   = 4;
   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned STALE_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      VID  = 2'b01,
      CPU  = 2'b10
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   out_upd;
   logic [STALE_W-1:0] stale;
   logic [STALE_W-1:0] stale_upd;
   logic [STALE_W:0]   stale_sum;
   logic [STALE_W-1:0] stale_hand;
   logic [WAIT_W-1:0]  cpu_wait;
   logic               full;
   logic               issue;
   logic               ack_live;
   logic               owner_cyc;

   assign full       = (outstanding == OUT_W'(MAX_OUTSTANDING));
   assign cpu_starve = (cpu_wait == WAIT_W'(CPU_WAIT_MAX));
   assign gnt        = 2'(state);
   // acks belonging to an aborted cycle are swallowed before any live ack is forwarded
   assign ack_live   = mem_ack & (stale == '0);
   assign issue      = mem_stb & ~mem_stall;

   // arbitration: in IDLE, or when the current owner has released cyc
   always_comb begin
      owner_cyc = 1'b0;
      state_nxt = state;
      case (state)
         VID:     owner_cyc = vid_cyc;
         CPU:     owner_cyc = cpu_cyc;
         default: owner_cyc = 1'b0;
      endcase
      if (state == IDLE || !owner_cyc) begin
         if (cpu_cyc && (!vid_cyc || cpu_starve)) state_nxt = CPU;
         else if (vid_cyc)                        state_nxt = VID;
         else                                     state_nxt = IDLE;
      end
   end

   // outstanding / stale-ack bookkeeping for the current cycle
   always_comb begin
      out_upd   = outstanding;
      stale_upd = stale;
      if (issue && !ack_live)                            out_upd = outstanding + OUT_W'(1);
      else if (!issue && ack_live && outstanding != '0)  out_upd = outstanding - OUT_W'(1);
      if (mem_ack && stale != '0) stale_upd = stale - STALE_W'(1);
      stale_sum  = {1'b0, stale_upd} + (STALE_W+1)'(out_upd);
      stale_hand = stale_sum[STALE_W] ? '1 : stale_sum[STALE_W-1:0];
   end

   // bus steering toward mem and back to the owner
   always_comb begin
      mem_cyc   = 1'b0;
      mem_stb   = 1'b0;
      mem_adr   = '0;
      mem_we    = 1'b0;
      mem_sel   = '0;
      mem_dat_m = '0;
      vid_dat_s = '0;
      vid_ack   = 1'b0;
      vid_stall = 1'b1;
      cpu_dat_s = '0;
      cpu_ack   = 1'b0;
      cpu_stall = 1'b1;
      case (state)
         VID: begin
            mem_cyc   = vid_cyc;
            mem_stb   = vid_stb & ~full;
            mem_adr   = vid_adr;
            mem_we    = vid_we;
            mem_sel   = vid_sel;
            mem_dat_m = vid_dat_m;
            vid_dat_s = mem_dat_s;
            vid_ack   = ack_live;
            vid_stall = mem_stall | full;
         end
         CPU: begin
            mem_cyc   = cpu_cyc;
            mem_stb   = cpu_stb & ~full;
            mem_adr   = cpu_adr;
            mem_we    = cpu_we;
            mem_sel   = cpu_sel;
            mem_dat_m = cpu_dat_m;
            cpu_dat_s = mem_dat_s;
            cpu_ack   = ack_live;
            cpu_stall = mem_stall | full;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         outstanding <= '0;
         stale       <= '0;
         cpu_wait    <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            outstanding <= '0;
            stale       <= stale_hand;
         end else begin
            outstanding <= out_upd;
            stale       <= stale_upd;
         end
         if (!cpu_cyc || state_nxt == CPU) cpu_wait <= '0;
         else if (!cpu_starve)             cpu_wait <= cpu_wait + WAIT_W'(1);
      end
   end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed scenarios then random traffic, all checked against
// a behavioural model of ownership, in-flight transfers, discarded acks and CPU wait time.
module tb_vga_mem_arbiter;

   localparam int MAXO = 2;
   localparam int WMAX = 64;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        vid_cyc, vid_stb, vid_we;
   logic [31:0] vid_adr, vid_dat_m;
   logic [3:0]  vid_sel;
   logic [31:0] vid_dat_s;
   logic        vid_ack, vid_stall;
   logic        cpu_cyc, cpu_stb, cpu_we;
   logic [31:0] cpu_adr, cpu_dat_m;
   logic [3:0]  cpu_sel;
   logic [31:0] cpu_dat_s;
   logic        cpu_ack, cpu_stall;
   logic        mem_cyc, mem_stb, mem_we;
   logic [31:0] mem_adr, mem_dat_m, mem_dat_s;
   logic [3:0]  mem_sel;
   logic        mem_ack, mem_stall;
   logic [1:0]  gnt;
   logic        cpu_starve;

   vga_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .CPU_WAIT_MAX(WMAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .vid_cyc(vid_cyc), .vid_stb(vid_stb), .vid_adr(vid_adr), .vid_we(vid_we),
      .vid_sel(vid_sel), .vid_dat_m(vid_dat_m), .vid_dat_s(vid_dat_s),
      .vid_ack(vid_ack), .vid_stall(vid_stall),
      .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_adr(cpu_adr), .cpu_we(cpu_we),
      .cpu_sel(cpu_sel), .cpu_dat_m(cpu_dat_m), .cpu_dat_s(cpu_dat_s),
      .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_adr(mem_adr), .mem_we(mem_we),
      .mem_sel(mem_sel), .mem_dat_m(mem_dat_m), .mem_dat_s(mem_dat_s),
      .mem_ack(mem_ack), .mem_stall(mem_stall),
      .gnt(gnt), .cpu_starve(cpu_starve)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // model: owner 0 none, 1 video, 2 cpu (matches the gnt code)
   int m_owner, m_out, m_stale, m_wait;
   int last_iss;

   logic        obs_mem_cyc, obs_mem_stb, obs_mem_we, obs_vid_ack, obs_cpu_ack, obs_cpu_stall;
   logic [31:0] obs_mem_adr, obs_mem_dat_m;
   logic [3:0]  obs_mem_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_out = 0; m_stale = 0; m_wait = 0; last_iss = 0;
   endtask

   task automatic check_all();
      logic        full, live;
      logic        e_cyc, e_stb, e_we, e_vack, e_vstall, e_cack, e_cstall;
      logic [31:0] e_adr, e_dat, e_vdat, e_cdat;
      logic [3:0]  e_sel;
      full = (m_out == MAXO);
      live = mem_ack && (m_stale == 0);
      e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0;
      e_vack = 0; e_vstall = 1; e_vdat = 0; e_cack = 0; e_cstall = 1; e_cdat = 0;
      if (m_owner == 1) begin
         e_cyc = vid_cyc; e_stb = vid_stb && !full; e_adr = vid_adr; e_we = vid_we;
         e_sel = vid_sel; e_dat = vid_dat_m;
         e_vack = live; e_vstall = mem_stall || full; e_vdat = mem_dat_s;
      end else if (m_owner == 2) begin
         e_cyc = cpu_cyc; e_stb = cpu_stb && !full; e_adr = cpu_adr; e_we = cpu_we;
         e_sel = cpu_sel; e_dat = cpu_dat_m;
         e_cack = live; e_cstall = mem_stall || full; e_cdat = mem_dat_s;
      end
      chk("gnt", 32'(gnt), 32'(m_owner));
      chk("cpu_starve", 32'(cpu_starve), 32'(m_wait == WMAX));
      chk("mem_cyc", 32'(mem_cyc), 32'(e_cyc));
      chk("mem_stb", 32'(mem_stb), 32'(e_stb));
      chk("mem_adr", mem_adr, e_adr);
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_sel", 32'(mem_sel), 32'(e_sel));
      chk("mem_dat_m", mem_dat_m, e_dat);
      chk("vid_ack", 32'(vid_ack), 32'(e_vack));
      chk("vid_stall", 32'(vid_stall), 32'(e_vstall));
      chk("vid_dat_s", vid_dat_s, e_vdat);
      chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
      chk("cpu_stall", 32'(cpu_stall), 32'(e_cstall));
      chk("cpu_dat_s", cpu_dat_s, e_cdat);
   endtask

   task automatic model_step();
      logic arb, stb, iss, live;
      int   nxt;
      if (!rst_i) begin
         model_reset();
         return;
      end
      arb = (m_owner == 0) || (m_owner == 1 && !vid_cyc) || (m_owner == 2 && !cpu_cyc);
      nxt = m_owner;
      if (arb) nxt = (cpu_cyc && (!vid_cyc || m_wait == WMAX)) ? 2 : (vid_cyc ? 1 : 0);
      stb  = (m_owner == 1) ? vid_stb : (m_owner == 2) ? cpu_stb : 1'b0;
      stb  = stb && (m_out != MAXO);
      iss  = stb && !mem_stall;
      live = mem_ack && (m_stale == 0);
      last_iss = int'(iss);
      if (mem_ack && m_stale > 0) m_stale--;
      if (iss && !live)                   m_out++;
      else if (!iss && live && m_out > 0) m_out--;
      if (nxt != m_owner) begin
         m_stale = (m_stale + m_out > 31) ? 31 : m_stale + m_out;
         m_out   = 0;
      end
      if (!cpu_cyc || nxt == 2) m_wait = 0;
      else if (m_wait < WMAX)   m_wait++;
      m_owner = nxt;
   endtask

   // one clock: compare on the falling edge, advance the model on the rising edge
   task automatic tick();
      @(negedge clk_i);
      check_all();
      obs_mem_cyc = mem_cyc; obs_mem_stb = mem_stb; obs_mem_we = mem_we;
      obs_mem_adr = mem_adr; obs_mem_sel = mem_sel; obs_mem_dat_m = mem_dat_m;
      obs_vid_ack = vid_ack; obs_cpu_ack = cpu_ack; obs_cpu_stall = cpu_stall;
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   task automatic set_vid(input logic cyc, input logic stb, input logic [31:0] adr,
                          input logic we, input logic [3:0] sel, input logic [31:0] dat);
      vid_cyc = cyc; vid_stb = stb; vid_adr = adr; vid_we = we; vid_sel = sel; vid_dat_m = dat;
   endtask

   task automatic set_cpu(input logic cyc, input logic stb, input logic [31:0] adr,
                          input logic we, input logic [3:0] sel, input logic [31:0] dat);
      cpu_cyc = cyc; cpu_stb = stb; cpu_adr = adr; cpu_we = we; cpu_sel = sel; cpu_dat_m = dat;
   endtask

   initial begin
      int n_iss, n_vack;
      rst_i = 1'b0;
      set_vid(0, 0, 0, 0, 0, 0);
      set_cpu(0, 0, 0, 0, 0, 0);
      mem_ack = 0; mem_stall = 0; mem_dat_s = 32'h0;
      model_reset();

      // reset values
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_vid_stall", 32'(vid_stall), 32'd1);
      rst_i = 1'b1;
      tick();

      // video burst of 4 pipelined reads
      set_vid(1, 1, 32'h0000_1000, 0, 4'hf, 0);
      mem_dat_s = 32'hCAFE_0001;
      tick();
      chk("a_gnt_vid", 32'(gnt), 32'd1);
      n_iss = 0; n_vack = 0;
      for (int k = 0; k < 16; k++) begin
         vid_stb = (n_iss < 4);
         vid_adr = 32'h0000_1000 + 32'(4 * n_iss);
         mem_ack = (m_out > 0) && (k >= 2);
         tick();
         n_iss += last_iss;
         n_vack += int'(obs_vid_ack);
         chk("a_cpu_stall", 32'(obs_cpu_stall), 32'd1);
      end
      chk("a_vid_acks", 32'(n_vack), 32'd4);
      mem_ack = 0;
      set_vid(0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // simultaneous requests: video first, cpu after a one-cycle gap
      set_vid(1, 1, 32'h0000_2000, 0, 4'hf, 0);
      set_cpu(1, 0, 32'h8000_0000, 1, 4'hf, 32'h1234_5678);
      tick();
      chk("c_gnt_vid", 32'(gnt), 32'd1);
      tick();
      tick();
      vid_stb = 0; mem_ack = 1;
      tick();
      tick();
      mem_ack = 0;
      vid_cyc = 0;
      tick();
      chk("c_gap", 32'(obs_mem_cyc), 32'd0);
      chk("c_gnt_cpu", 32'(gnt), 32'd2);
      cpu_cyc = 0;
      tick();

      // starvation: video holds the bus, cpu waits
      set_vid(1, 0, 32'h0000_3000, 0, 4'hf, 0);
      set_cpu(1, 0, 32'h8000_0100, 1, 4'hf, 0);
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 63) chk("d_starve_63", 32'(cpu_starve), 32'd0);
         if (k == 64) chk("d_starve_64", 32'(cpu_starve), 32'd1);
      end
      vid_cyc = 0;
      tick();
      chk("d_cpu_wins", 32'(gnt), 32'd2);
      vid_cyc = 1;
      tick();
      chk("d_cpu_holds", 32'(gnt), 32'd2);

      // cpu byte write passes through untouched
      set_cpu(1, 1, 32'h8000_0042, 1, 4'b0100, 32'h00AB_0000);
      mem_ack = 1;
      tick();
      chk("e_adr", obs_mem_adr, 32'h8000_0042);
      chk("e_sel", 32'(obs_mem_sel), 32'h4);
      chk("e_dat", obs_mem_dat_m, 32'h00AB_0000);
      chk("e_we", 32'(obs_mem_we), 32'd1);
      chk("e_cpu_ack", 32'(obs_cpu_ack), 32'd1);
      mem_ack = 0;
      set_cpu(0, 0, 0, 0, 0, 0);
      vid_cyc = 0;
      tick();

      // video aborts with 2 in flight; late acks are swallowed
      set_vid(1, 1, 32'h0000_4000, 0, 4'hf, 0);
      set_cpu(1, 0, 32'h8000_0200, 1, 4'hf, 32'h5555_AAAA);
      tick();
      tick();
      tick();
      set_vid(0, 0, 0, 0, 0, 0);
      tick();
      chk("f_gnt_cpu", 32'(gnt), 32'd2);
      mem_ack = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("f_late_vid_ack", 32'(obs_vid_ack), 32'd0);
         chk("f_late_cpu_ack", 32'(obs_cpu_ack), 32'd0);
      end
      mem_ack = 0; cpu_stb = 1;
      tick();
      tick();
      tick();
      chk("f_full_stall", 32'(obs_cpu_stall), 32'd1);
      chk("f_full_stb", 32'(obs_mem_stb), 32'd0);
      mem_ack = 1;
      tick();
      chk("f_live_ack", 32'(obs_cpu_ack), 32'd1);
      mem_ack = 0;
      tick();
      chk("f_reissue", 32'(obs_mem_stb), 32'd1);
      cpu_stb = 0; mem_ack = 1;
      tick();
      tick();
      mem_ack = 0;
      cpu_cyc = 0;
      tick();

      // asynchronous reset in the middle of a video cycle
      set_vid(1, 1, 32'h0000_5000, 0, 4'hf, 0);
      tick();
      tick();
      #2;
      rst_i = 0;
      #1;
      chk("g_async_cyc", 32'(mem_cyc), 32'd0);
      chk("g_async_gnt", 32'(gnt), 32'd0);
      model_reset();
      mem_ack = 1;
      tick();
      chk("g_rst_ack", 32'(obs_vid_ack), 32'd0);
      mem_ack = 0;
      set_vid(0, 0, 0, 0, 0, 0);
      rst_i = 1;
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) vid_cyc = ~vid_cyc;
         if ($urandom_range(0, 9) == 0) cpu_cyc = ~cpu_cyc;
         vid_stb   = ($urandom_range(0, 3) != 0);
         cpu_stb   = ($urandom_range(0, 3) != 0);
         vid_adr   = $urandom;
         cpu_adr   = $urandom;
         vid_we    = 1'($urandom);
         cpu_we    = 1'($urandom);
         vid_sel   = 4'($urandom);
         cpu_sel   = 4'($urandom);
         vid_dat_m = $urandom;
         cpu_dat_m = $urandom;
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_stall = ($urandom_range(0, 3) == 0);
         mem_dat_s = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Two-master Wishbone arbiter that shares the single video memory port between the display fetch engine (text or graphics driver, already muxed by `vga_master`) and a CPU/DMA master writing the frame buffer. Video fetch has priority. A wait counter guarantees CPU progress between video bus cycles. Grant is held for a whole Wishbone bus cycle (`cyc` high) and is never pre-empted. Outstanding pipelined transfers are tracked and limited. Sits between `vga_master.outbus` / the CPU fabric and the SDRAM/SRAM controller slave.

## Interface
- `MAX_OUTSTANDING`, 8: max issued-but-unacked transfers on `mem`; range 1..15.
- `CPU_WAIT_MAX`, 64: CPU wait cycles after which CPU wins the next arbitration over video; range 1..255.
- `clk_i` input 1: system clock; all logic in this single domain.
- `rst_i` input 1: asynchronous, active-low reset.
- `vid` if_wb.slave: video fetch requester (cyc, stb, adr[31:0], we, sel[3:0], dat_m[31:0] in; dat_s[31:0], ack, stall out).
- `cpu` if_wb.slave: CPU/DMA requester, same signal set.
- `mem` if_wb.master: shared memory port.
- `gnt` output 2: 2'b00 idle, 2'b01 video owns, 2'b10 CPU owns.
- `cpu_starve` output 1: high while the CPU wait counter is at `CPU_WAIT_MAX`.

## Operation
- States: IDLE, VID, CPU. `gnt` encodes the state directly.
- Arbitration runs in IDLE, and in an owned state on the cycle the owner's `cyc` is low.
- Arbitration rule: CPU wins if `cpu.cyc` and (`!vid.cyc` or `cpu_starve`). Otherwise video wins if `vid.cyc`. Otherwise go to IDLE.
- In VID or CPU, `mem.cyc/stb/adr/we/sel/dat_m` = owner's signals.
  - Exception: `mem.stb` is gated low when `outstanding == MAX_OUTSTANDING`.
- Owner sees `ack = mem.ack` and `dat_s = mem.dat_s`.
- Owner sees `stall = mem.stall | (outstanding == MAX_OUTSTANDING)`.
- Non-owner sees `stall = 1`, `ack = 0`, `dat_s = 0`.
- In IDLE: all `mem` outputs are 0, and both requesters see `stall = 1`, `ack = 0`.
- `outstanding` (4 bits) updates by +1 on an accepted issue (`mem.stb & !mem.stall`) and −1 on `mem.ack`.
  - Simultaneous issue and ack: no change.
  - Cleared to 0 on every grant change.
  - Never wraps: an ack at 0 leaves it at 0.
- CPU wait counter (8 bits):
  - Increments each cycle `cpu.cyc` is high and the state is not CPU.
  - Saturates at `CPU_WAIT_MAX`.
  - Clears when the state enters CPU or `cpu.cyc` is low.
- Owner dropping `cyc` with transfers outstanding aborts the cycle. Late `mem.ack`s after the grant change are dropped: they are not forwarded to either requester.
- Writes pass `sel` unchanged. The arbiter never modifies data.

## Timing
- Reset (`rst_i` low, async) values: state IDLE, `gnt` = 0, `cpu_starve` = 0, both counters 0, all `mem` outputs 0, both requester `stall` = 1, `ack` = 0.
- Grant latency: a request arriving in IDLE in cycle N becomes the owner in N+1. `mem.cyc` rises in N+1.
- Handoff: owner `cyc` falls in N. The new owner (or IDLE) takes effect in N+1. `mem.cyc` is low in N, so there is at least one idle cycle between owners.
- Back-to-back cycles by the same owner also see the one-cycle gap. Re-arbitration applies, so a starved CPU takes over.
- Outputs toward `mem` and the requesters are combinational from state, counters and inputs. There is no added pipeline latency within a grant.
- Reset mid-transfer: `mem.cyc` drops asynchronously. Any returning ack is dropped.

## Test plan
- Reset, then `vid.cyc` held with 4 pipelined reads → `gnt` = 01 the cycle after request, 4 acks forwarded to `vid`, `cpu` sees `stall` = 1 throughout.
- `vid` and `cpu` both raise `cyc` in the same cycle from IDLE, `cpu_starve` = 0 → video granted. After `vid.cyc` drops, CPU is granted the next cycle with one `mem.cyc` = 0 cycle between the two owners.
- Video holds `cyc` for 100 cycles while `cpu.cyc` is high → `cpu_starve` rises after 64 cycles. At the video release, CPU wins even though `vid.cyc` is re-asserted.
- `MAX_OUTSTANDING` = 2, `mem` withholds ack → third `stb` sees `stall` = 1 and `mem.stb` = 0. One ack releases one further issue.
- CPU byte write with `sel` = 4'b0100, data 0x00AB0000 → `mem` shows identical `adr`, `sel` and `dat_m`, and `cpu.ack` is asserted in the same cycle as `mem.ack`.
- Owner drops `cyc` with 2 outstanding, then `mem` returns 2 acks after CPU is granted → neither requester sees those acks, and the CPU `outstanding` count starts at 0.
